// File: rtl/rst_seq_gen.sv
// Synchronises the board reset and releases NUM_RST reset domains in a fixed staged order, then emits a heartbeat tick.
// Latency: bit i is released SYNC_STAGES+POR_CYCLES+i*STAGE_CYCLES clocks after rst_n rises; all outputs are registered.
// Backpressure: none. A sw_rst request restarts the release sequence, and it is held in POR_WAIT while sw_rst stays high.
module rst_seq_gen #(
   parameter int NUM_RST      = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int POR_CYCLES   = 100,
   parameter int STAGE_CYCLES = 16,
   parameter int TICK_DIV     = 50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sw_rst,
   output logic [NUM_RST-1:0] rst_n_out,
   output logic               seq_done,
   output logic               tick
);

   localparam int MAX_AB = (POR_CYCLES > STAGE_CYCLES) ? POR_CYCLES : STAGE_CYCLES;
   localparam int MAX_C  = (MAX_AB > TICK_DIV) ? MAX_AB : TICK_DIV;
   localparam int CW     = $clog2(MAX_C) + 1;
   localparam int IW     = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

   localparam logic [CW-1:0] POR_TC   = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] STG_TC   = CW'(STAGE_CYCLES - 1);
   localparam logic [CW-1:0] TICK_TC  = CW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RST - 1);

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      POR_WAIT = 2'd1,
      RELEASE  = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [CW-1:0]      tick_cnt, tick_cnt_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [NUM_RST-1:0] rst_nxt;
   logic               done_nxt;
   logic               tick_nxt;
   logic [CW-1:0]      por_cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic               sync_out;

   assign sync_out = sync[SYNC_STAGES-1];

   // The HOLD->POR_WAIT edge counts as the first POR cycle, so HOLD is treated as count 0.
   assign por_cnt = (state == HOLD) ? '0 : cnt;

   // Reset-deassert synchroniser: a constant 1 shifts in after rst_n releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // State, counter and registered output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HOLD;
         cnt       <= '0;
         tick_cnt  <= '0;
         idx       <= '0;
         rst_n_out <= '0;
         seq_done  <= 1'b0;
         tick      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         tick_cnt  <= tick_cnt_nxt;
         idx       <= idx_nxt;
         rst_n_out <= rst_nxt;
         seq_done  <= done_nxt;
         tick      <= tick_nxt;
      end
   end

   // Next-state and next-output logic; sw_rst overrides everything outside HOLD.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      tick_cnt_nxt = tick_cnt;
      idx_nxt      = idx;
      rst_nxt      = rst_n_out;
      done_nxt     = seq_done;
      tick_nxt     = 1'b0;

      case (state)
         HOLD, POR_WAIT: begin
            if ((state == POR_WAIT) || sync_out) begin
               if (por_cnt == POR_TC) begin
                  rst_nxt[0] = 1'b1;
                  cnt_nxt    = '0;
                  if (NUM_RST == 1) begin
                     state_nxt    = DONE;
                     done_nxt     = 1'b1;
                     tick_cnt_nxt = '0;
                  end else begin
                     state_nxt = RELEASE;
                     idx_nxt   = IW'(1);
                  end
               end else begin
                  cnt_nxt   = por_cnt + CW'(1);
                  state_nxt = POR_WAIT;
               end
            end
         end
         RELEASE: begin
            if (cnt == STG_TC) begin
               cnt_nxt = '0;
               for (int i = 0; i < NUM_RST; i++) begin
                  if (IW'(i) == idx) begin
                     rst_nxt[i] = 1'b1;
                  end
               end
               if (idx == IDX_LAST) begin
                  state_nxt    = DONE;
                  done_nxt     = 1'b1;
                  tick_cnt_nxt = '0;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            if (tick_cnt == TICK_TC) begin
               tick_cnt_nxt = '0;
               tick_nxt     = 1'b1;
            end else begin
               tick_cnt_nxt = tick_cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = HOLD;
         end
      endcase

      if (sw_rst && (state != HOLD)) begin
         state_nxt    = POR_WAIT;
         cnt_nxt      = '0;
         tick_cnt_nxt = '0;
         idx_nxt      = '0;
         rst_nxt      = '0;
         done_nxt     = 1'b0;
         tick_nxt     = 1'b0;
      end
   end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default instance plus a NUM_RST=1 / POR_CYCLES=1 instance.
// Expected outputs come from release-edge arithmetic on a per-instance base edge.
// Directed table, hand sequences for sw_rst and async reset, then random stimulus.
module tb_rst_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b, sw_rst;
   logic [3:0] rno_a;
   logic       done_a, tick_a;
   logic [0:0] rno_b;
   logic       done_b, tick_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ra, rb, base_a, base_b;
   bit in_a, in_b;

   always #10 clk = ~clk;

   rst_seq_gen dut_a (
      .clk(clk), .rst_n(rst_n_a), .sw_rst(sw_rst),
      .rst_n_out(rno_a), .seq_done(done_a), .tick(tick_a)
   );

   rst_seq_gen #(.NUM_RST(1), .SYNC_STAGES(2), .POR_CYCLES(1), .STAGE_CYCLES(16), .TICK_DIV(4)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .sw_rst(sw_rst),
      .rst_n_out(rno_b), .seq_done(done_b), .tick(tick_b)
   );

   typedef struct {
      int         rel;
      bit         chk_a;
      logic [3:0] ra_exp;
      logic       da_exp;
      logic       ta_exp;
      bit         chk_b;
      logic       rb_exp;
      logic       db_exp;
      logic       tb_exp;
   } vec_t;

   vec_t tbl[$];

   // Expected {tick, done, rst_n_out} after edge c: bit i is released at base+por+i*stg.
   function automatic logic [5:0] model(int n, int por, int stg, int td, int base, int c, bit inrst);
      logic [5:0] v;
      int last;
      v = '0;
      if (inrst) return v;
      for (int i = 0; i < n; i++) begin
         if (c >= base + por + i * stg) v[i] = 1'b1;
      end
      last = base + por + (n - 1) * stg;
      v[4] = (c >= last);
      v[5] = (c > last) && (((c - last) % td) == 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   // One clock: sample sw_rst on the edge as the DUT does, then compare at the falling edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      if (!in_a && sw_rst && cyc >= ra + 4) base_a = cyc;
      if (!in_b && sw_rst && cyc >= rb + 4) base_b = cyc;
      @(negedge clk);
      chk("model_a", {26'd0, tick_a, done_a, rno_a}, {26'd0, model(4, 100, 16, 50, base_a, cyc, in_a)});
      chk("model_b", {26'd0, tick_b, done_b, 3'b000, rno_b}, {26'd0, model(1, 1, 16, 4, base_b, cyc, in_b)});
   endtask

   task automatic set_rst_a(input bit v);
      rst_n_a = v;
      in_a    = !v;
      if (v) begin
         ra     = cyc;
         base_a = cyc + 2;
      end
   endtask

   task automatic set_rst_b(input bit v);
      rst_n_b = v;
      in_b    = !v;
      if (v) begin
         rb     = cyc;
         base_b = cyc + 2;
      end
   endtask

   task automatic run_to_a(input int rel);
      while (cyc - ra < rel) step();
   endtask

   int sw_left;

   initial begin
      sw_rst = 1'b0;
      set_rst_a(1'b0);
      set_rst_b(1'b0);
      ra = 0; rb = 0; base_a = 0; base_b = 0;

      tbl.push_back(vec_t'{2,   1, 4'b0000, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{3,   0, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0});
      tbl.push_back(vec_t'{6,   0, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0});
      tbl.push_back(vec_t'{7,   0, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1});
      tbl.push_back(vec_t'{11,  0, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1});
      tbl.push_back(vec_t'{101, 1, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{102, 1, 4'b0001, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{117, 1, 4'b0001, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{118, 1, 4'b0011, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{133, 1, 4'b0011, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{134, 1, 4'b0111, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{149, 1, 4'b0111, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{150, 1, 4'b1111, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{199, 1, 4'b1111, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{200, 1, 4'b1111, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{201, 1, 4'b1111, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{250, 1, 4'b1111, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0});

      // Reset held low for 100 ns, then released on a falling edge.
      repeat (5) step();
      chk("reset_rno_a", {28'd0, rno_a}, 32'd0);
      chk("reset_done_a", {31'd0, done_a}, 32'd0);
      set_rst_a(1'b1);
      set_rst_b(1'b1);

      // Power-on release order and heartbeat.
      foreach (tbl[k]) begin
         run_to_a(tbl[k].rel);
         if (tbl[k].chk_a) begin
            chk($sformatf("tbl_rno_a@%0d", tbl[k].rel), {28'd0, rno_a}, {28'd0, tbl[k].ra_exp});
            chk($sformatf("tbl_done_a@%0d", tbl[k].rel), {31'd0, done_a}, {31'd0, tbl[k].da_exp});
            chk($sformatf("tbl_tick_a@%0d", tbl[k].rel), {31'd0, tick_a}, {31'd0, tbl[k].ta_exp});
         end
         if (tbl[k].chk_b) begin
            chk($sformatf("tbl_rno_b@%0d", tbl[k].rel), {31'd0, rno_b}, {31'd0, tbl[k].rb_exp});
            chk($sformatf("tbl_done_b@%0d", tbl[k].rel), {31'd0, done_b}, {31'd0, tbl[k].db_exp});
            chk($sformatf("tbl_tick_b@%0d", tbl[k].rel), {31'd0, tick_b}, {31'd0, tbl[k].tb_exp});
         end
      end

      // One-cycle sw_rst pulse: outputs clear next edge, re-release POR_CYCLES later.
      run_to_a(269);
      sw_rst = 1'b1;
      step();
      sw_rst = 1'b0;
      chk("sw_pulse_rno", {28'd0, rno_a}, 32'd0);
      chk("sw_pulse_done", {31'd0, done_a}, 32'd0);
      chk("sw_pulse_tick", {31'd0, tick_a}, 32'd0);
      run_to_a(369);
      chk("sw_pulse_pre", {28'd0, rno_a}, 32'd0);
      run_to_a(370);
      chk("sw_pulse_rel", {28'd0, rno_a}, 32'd1);

      // Async reset mid-RELEASE, then restart with sw_rst high during HOLD.
      run_to_a(386);
      chk("mid_release", {28'd0, rno_a}, 32'd3);
      #3;
      set_rst_a(1'b0);
      #1;
      chk("async_rno", {28'd0, rno_a}, 32'd0);
      chk("async_done", {31'd0, done_a}, 32'd0);
      step();
      step();
      set_rst_a(1'b1);
      sw_rst = 1'b1;
      repeat (3) step();
      sw_rst = 1'b0;
      run_to_a(101);
      chk("restart_pre", {28'd0, rno_a}, 32'd0);
      run_to_a(102);
      chk("restart_bit0", {28'd0, rno_a}, 32'd1);
      run_to_a(150);
      chk("restart_done", {31'd0, done_a}, 32'd1);

      // sw_rst held for 30 edges: release 100 edges after the last high sample.
      run_to_a(160);
      sw_rst = 1'b1;
      repeat (30) step();
      sw_rst = 1'b0;
      run_to_a(289);
      chk("sw_hold_pre", {28'd0, rno_a}, 32'd0);
      run_to_a(290);
      chk("sw_hold_rel", {28'd0, rno_a}, 32'd1);

      // Sub-cycle rst_n glitch on the single-output instance.
      run_to_a(300);
      chk("b_before_glitch", {31'd0, rno_b}, 32'd1);
      #2;
      set_rst_b(1'b0);
      #1;
      chk("glitch_rno_b", {31'd0, rno_b}, 32'd0);
      chk("glitch_done_b", {31'd0, done_b}, 32'd0);
      #3;
      set_rst_b(1'b1);
      while (cyc - rb < 2) step();
      chk("glitch_b_pre", {31'd0, rno_b}, 32'd0);
      step();
      chk("glitch_b_rel", {31'd0, rno_b}, 32'd1);

      // Random phase: occasional sw_rst bursts, async resets and glitches.
      sw_left = 0;
      for (int it = 0; it < 4000; it++) begin
         if (sw_left > 0) begin
            sw_left--;
            sw_rst = 1'b1;
         end else begin
            sw_rst = 1'b0;
            if ($urandom_range(0, 249) == 0) sw_left = $urandom_range(1, 40);
         end
         if ($urandom_range(0, 399) == 0) begin
            #3;
            set_rst_a(1'b0);
            #1;
            chk("rand_async_a", {28'd0, rno_a}, 32'd0);
            repeat ($urandom_range(1, 3)) step();
            set_rst_a(1'b1);
         end
         if ($urandom_range(0, 299) == 0) begin
            #2;
            set_rst_b(1'b0);
            #1;
            chk("rand_glitch_b", {31'd0, rno_b}, 32'd0);
            #3;
            set_rst_b(1'b1);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
